// File: rtl/rr_prio_arbiter_seq.sv
// Registered N-way arbiter: fixed-priority or round-robin search with grant hold limiting.
// Latency: one cycle from req to grant, and all outputs are registered.
// No backpressure. req is level-sensitive and a released owner is re-arbitrated in the same edge.
// Optional macro ARB_STARVE_DET_EN adds per-requester wait counters and a registered starve flag.
module rr_prio_arbiter_seq #(
   parameter int N        = 128,
   parameter int MAX_HOLD = 16,
`ifdef ARB_STARVE_DET_EN
   parameter int STARVE_LIMIT = 4 * N,
`endif
   localparam int IDX_W   = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic [N-1:0]     priority_in,
   input  logic [N-1:0]     req,
`ifdef ARB_STARVE_DET_EN
   output logic             starve,
`endif
   output logic [N-1:0]     grant,
   output logic             any_grant,
   output logic [IDX_W-1:0] grant_idx
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   typedef enum logic {IDLE, OWNED} state_t;

   state_t            state, nxt_state;
   logic [HOLD_W-1:0] hold_cnt, nxt_hold;
   logic [IDX_W-1:0]  rr_ptr, nxt_ptr;
   logic [N-1:0]      nxt_grant;
   logic [IDX_W-1:0]  nxt_idx;
   logic [IDX_W-1:0]  prio_idx, start_idx, win_idx;
   logic [N-1:0]      search_req;
   logic              found, take_new;

   // Start index; anything other than exactly one-hot selects bit 0.
   always_comb begin
      prio_idx = '0;
      if (priority_in != '0 && (priority_in & (priority_in - 1'b1)) == '0) begin
         for (int i = 0; i < N; i++) begin
            if (priority_in[i]) prio_idx = i[IDX_W-1:0];
         end
      end
      start_idx = mode ? rr_ptr : prio_idx;
   end

   // The current owner never competes: it either released or is being forced off.
   always_comb begin
      search_req = req & ~grant;
      found      = 1'b0;
      win_idx    = '0;
      for (int i = 0; i < N; i++) begin
         int j;
         j = (int'(start_idx) + i) % N;
         if (!found && search_req[j]) begin
            found   = 1'b1;
            win_idx = j[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_grant = grant;
      nxt_idx   = grant_idx;
      nxt_hold  = hold_cnt;
      nxt_ptr   = rr_ptr;
      take_new  = 1'b0;
      case (state)
         IDLE: take_new = found;
         OWNED: begin
            if (!req[grant_idx]) begin
               if (found) begin
                  take_new = 1'b1;
               end else begin
                  nxt_state = IDLE;
                  nxt_grant = '0;
                  nxt_idx   = '0;
                  nxt_hold  = '0;
               end
            end else if (hold_cnt == HOLD_W'(MAX_HOLD)) begin
               take_new = found;
            end else begin
               nxt_hold = hold_cnt + 1'b1;
            end
         end
         default: nxt_state = IDLE;
      endcase
      if (take_new) begin
         nxt_state          = OWNED;
         nxt_grant          = '0;
         nxt_grant[win_idx] = 1'b1;
         nxt_idx            = win_idx;
         nxt_hold           = HOLD_W'(1);
         nxt_ptr            = (win_idx == IDX_W'(N - 1)) ? '0 : win_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= '0;
         any_grant <= 1'b0;
         grant_idx <= '0;
         hold_cnt  <= '0;
         rr_ptr    <= '0;
      end else begin
         state     <= nxt_state;
         grant     <= nxt_grant;
         any_grant <= |nxt_grant;
         grant_idx <= nxt_idx;
         hold_cnt  <= nxt_hold;
         rr_ptr    <= nxt_ptr;
      end
   end

`ifdef ARB_STARVE_DET_EN
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   logic [SC_W-1:0] wait_cnt [N];
   logic [SC_W-1:0] wait_nxt [N];
   logic            starve_nxt;

   // A requester waits while it asks but is not granted on this edge.
   always_comb begin
      starve_nxt = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!req[i] || nxt_grant[i]) begin
            wait_nxt[i] = '0;
         end else if (wait_cnt[i] != SC_W'(STARVE_LIMIT)) begin
            wait_nxt[i] = wait_cnt[i] + 1'b1;
         end else begin
            wait_nxt[i] = wait_cnt[i];
         end
         if (wait_nxt[i] == SC_W'(STARVE_LIMIT)) starve_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve <= 1'b0;
         for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
      end else begin
         starve <= starve_nxt;
         for (int i = 0; i < N; i++) wait_cnt[i] <= wait_nxt[i];
      end
   end
`endif

endmodule
